// File: rtl/video_expand.sv
// video_expand: palette lookup of core pixel indices into 24-bit RGB with a
// two-stage ce_pix pipeline, palette loadable over the ioctl download port.
module video_expand #(
    parameter int          BPP        = 1,
    parameter logic [7:0]  PAL_INDEX  = 8'h03,
    parameter bit          BLANK_ZERO = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce_pix,
    input  logic [BPP-1:0] pix,
    input  logic           hs_in,
    input  logic           vs_in,
    input  logic           hb_in,
    input  logic           vb_in,
    input  logic           ioctl_download,
    input  logic           ioctl_wr,
    input  logic [7:0]     ioctl_index,
    input  logic [24:0]    ioctl_addr,
    input  logic [7:0]     ioctl_dout,
    output logic [7:0]     vga_r,
    output logic [7:0]     vga_g,
    output logic [7:0]     vga_b,
    output logic           vga_hs,
    output logic           vga_vs,
    output logic           vga_hb,
    output logic           vga_vb,
    output logic           ioctl_wait
);
    localparam int N = 1 << BPP;

    function automatic logic [7:0] grey(input int i);
        logic [BPP-1:0] v;
        v = BPP'(i);
        return {(8 / BPP){v}};
    endfunction

    logic [23:0]    pal [N];
    logic [BPP-1:0] s1_pix;
    logic [3:0]     s1_sb;
    logic [BPP-1:0] entry;
    logic           we;

    assign ioctl_wait = 1'b0;
    assign entry      = ioctl_addr[BPP+1:2];
    // upper address bits must be zero so out-of-range writes never alias
    assign we = ioctl_download & ioctl_wr & (ioctl_index == PAL_INDEX)
              & (ioctl_addr[24:BPP+2] == '0);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            for (int i = 0; i < N; i++) pal[i] <= {3{grey(i)}};
        else if (we)
            pal[entry] <= {ioctl_addr[1:0] == 2'd0 ? ioctl_dout : pal[entry][23:16],
                           ioctl_addr[1:0] == 2'd1 ? ioctl_dout : pal[entry][15:8],
                           ioctl_addr[1:0] == 2'd2 ? ioctl_dout : pal[entry][7:0]};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1_pix                           <= '0;
            s1_sb                            <= '0;
            {vga_r, vga_g, vga_b}            <= '0;
            {vga_hs, vga_vs, vga_hb, vga_vb} <= '0;
        end else if (ce_pix) begin
            s1_pix                           <= pix;
            s1_sb                            <= {hs_in, vs_in, hb_in, vb_in};
            {vga_r, vga_g, vga_b}            <= (BLANK_ZERO && (s1_sb[1] | s1_sb[0])) ? 24'd0 : pal[s1_pix];
            {vga_hs, vga_vs, vga_hb, vga_vb} <= s1_sb;
        end
endmodule

// File: doc/video_expand.md
VIDEO_EXPAND -- requirements
Module: video_expand

Interface
REQ-001 SHALL provide parameter BPP, default 1, meaning pixel index width in bits; legal values 1, 2, 4, 8.
REQ-002 SHALL provide parameter PAL_INDEX, default 8'h03, meaning the ioctl_index value that selects palette download.
REQ-003 SHALL provide parameter BLANK_ZERO, default 1, meaning RGB is forced to zero during blanking.
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port ce_pix, input, 1 bit, pixel clock enable.
REQ-007 SHALL have port pix, input, BPP bits, palette index from the core.
REQ-008 SHALL have ports hs_in, vs_in, hb_in, vb_in, input, 1 bit each, core sync and blank.
REQ-009 SHALL have ports ioctl_download, ioctl_wr, input, 1 bit each; ioctl_index, input, 8 bits; ioctl_addr, input, 25 bits; ioctl_dout, input, 8 bits.
REQ-010 SHALL have ports vga_r, vga_g, vga_b, output, 8 bits each, expanded colour.
REQ-011 SHALL have ports vga_hs, vga_vs, vga_hb, vga_vb, output, 1 bit each, sync and blank aligned to colour.
REQ-012 SHALL have port ioctl_wait, output, 1 bit, tied 0.

Function
REQ-013 Palette SHALL hold 2^BPP entries, each 24 bits {R,G,B}.
REQ-014 Palette write SHALL occur on a cycle with ioctl_download=1, ioctl_wr=1, ioctl_index=PAL_INDEX.
- entry = ioctl_addr[BPP+1:2].
- component from ioctl_addr[1:0]: 0=R, 1=G, 2=B, 3=ignored.
REQ-015 Writes with ioctl_addr >= 4*2^BPP SHALL be ignored, with no aliasing.
REQ-016 Palette writes SHALL be independent of ce_pix and SHALL take effect on the next clk edge.
REQ-017 Pipeline stage 1, on each clk with ce_pix=1: SHALL register pix, hs_in, vs_in, hb_in, vb_in.
REQ-018 Pipeline stage 2, on each clk with ce_pix=1: SHALL register palette[stage1 pix] into vga_r/g/b, and stage1 sync/blank into vga_hs/vs/hb/vb.
REQ-019 Latency from input to output SHALL be exactly 2 ce_pix-qualified edges.
REQ-020 With ce_pix=0, all pipeline registers SHALL hold their values.
REQ-021 If BLANK_ZERO=1 and stage1 (hb|vb)=1, stage 2 SHALL load RGB 0.
REQ-022 If BLANK_ZERO=0, blanking SHALL NOT alter RGB.
REQ-023 A palette write and a stage-2 read of the same entry in the same cycle SHALL return the old value; the new value SHALL be visible from the next read.
REQ-024 Simultaneous writes cannot occur (one ioctl port), so no arbitration SHALL be required.
REQ-025 Sync and blank SHALL pass through unmodified apart from the delay.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately clear all pipeline registers and outputs to 0; ioctl_wait SHALL stay 0.
REQ-027 On reset, palette entry i SHALL be loaded with grey: each channel = i bit-replicated to 8 bits.
- BPP=1: 00, FF.
- BPP=2: 00, 55, AA, FF.
- BPP=4: i*0x11.
- BPP=8: i.
REQ-028 Reset mid-download SHALL discard the partial entry and restore the default palette.
REQ-029 Palette writes SHALL be inhibited while reset_n=0.
REQ-030 The first valid output SHALL appear 2 ce_pix edges after reset release.

Verification
REQ-031 BPP=1, ce_pix=1, pix=1 then 0, hb=vb=0.
- Response: RGB FFFFFF then 000000, each 2 clocks after input.
REQ-032 BPP=2, download at PAL_INDEX: addr 8,9,10 = 12,34,56; then pix=2.
- Response: RGB 123456.
- Write to addr 11, and to addr 16 (out of range): no palette change.
REQ-033 ce_pix pulsing 1 of 4 cycles, pix stepping 0..3.
- Response: outputs change only on ce_pix edges; latency is 2 enabled edges.
REQ-034 hb=1 with pix=3, BLANK_ZERO=1.
- Response: RGB 000000 and vga_hb=1, aligned.
- Same stimulus with BLANK_ZERO=0: RGB FFFFFF.
REQ-035 Write entry 1 R=00 in the same cycle as stage-2 read of entry 1.
- Response: that output R=FF.
- Next read: R=00.
REQ-036 reset_n pulsed low after a partial palette write.
- Response: outputs immediately 0.
- After release, entry 1 reads back at its default (BPP=2: 555555).
